// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and types for the polar<->rect conversion blocks.
// Angles use 65536 = 360 deg; x/y are Q18.16 signed.
package cordic_pkg;
  localparam int NUM_ITERS = 15;
  localparam int MAX_ITERS = 15;
  localparam logic [15:0] INV_K = 16'd39797;
  localparam int ATAN_TAB [MAX_ITERS] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                                          41, 20, 10, 5, 3, 1, 1};

  typedef logic [1:0]          quad_t;
  typedef logic signed [33:0]  cordic_xy_t;
  typedef logic signed [16:0]  cordic_z_t;

  // Q18.16 -> Q16.0 round-half-up, clamped symmetric so the quadrant negation cannot overflow.
  function automatic logic signed [15:0] round_sat(input cordic_xy_t v);
    cordic_xy_t r;
    r = (v + cordic_xy_t'(34'sd32768)) >>> 16;
    if (r > cordic_xy_t'(34'sd32767))       return 16'sd32767;
    else if (r < cordic_xy_t'(-34'sd32767)) return -16'sd32767;
    return r[15:0];
  endfunction
endpackage

// File: rtl/cordic_polar_to_rect_if.sv
// AXI4-Stream beat bundle with master/slave views.
interface cordic_polar_to_rect_if #(parameter int DATA_W = 32);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tstrb;

  modport master(output tvalid, tlast, tdata, tstrb, input tready);
  modport slave (input tvalid, tlast, tdata, tstrb, output tready);
endinterface

// File: rtl/cordic_rot_stage.sv
// One registered rotation-mode CORDIC micro-rotation; sidebands ride along.
module cordic_rot_stage import cordic_pkg::*; #(
  parameter int SHIFT = 0,
  parameter int ATAN  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  cordic_xy_t x,
  input  cordic_xy_t y,
  input  cordic_z_t  z,
  input  quad_t      quad,
  input  logic       vld,
  input  logic       last,
  input  logic [3:0] strb,
  output cordic_xy_t x_q,
  output cordic_xy_t y_q,
  output cordic_z_t  z_q,
  output quad_t      quad_q,
  output logic       vld_q,
  output logic       last_q,
  output logic [3:0] strb_q
);
  localparam cordic_z_t ATAN_Z = cordic_z_t'(ATAN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      quad_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      strb_q <= 4'hF;
    end else if (en) begin
      quad_q <= quad;
      vld_q  <= vld;
      last_q <= last;
      strb_q <= strb;
      if (!z[16]) begin
        x_q <= x - (y >>> SHIFT);
        y_q <= y + (x >>> SHIFT);
        z_q <= z - ATAN_Z;
      end else begin
        x_q <= x + (y >>> SHIFT);
        y_q <= y - (x >>> SHIFT);
        z_q <= z + ATAN_Z;
      end
    end
  end
endmodule

// File: rtl/cordic_polar_to_rect.sv
// Pipelined rotation CORDIC: {angle, magnitude} -> {Q, I}, fold + NUM_ITERS stages + unfold.
module cordic_polar_to_rect import cordic_pkg::*; #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int NUM_ITERS              = cordic_pkg::NUM_ITERS
) (
  input logic                    s00_axis_aclk,
  input logic                    s00_axis_aresetn,
  cordic_polar_to_rect_if.slave  s00_axis,
  cordic_polar_to_rect_if.master m00_axis
);
  // Downstream ready freezes the whole pipeline, so upstream ready is the same wire.
  logic en;
  assign en              = m00_axis.tready;
  assign s00_axis.tready = en;

  logic [15:0] angle, mag;
  assign angle = s00_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1 -: 16];
  assign mag   = s00_axis.tdata[15:0];

  cordic_xy_t         x_pipe    [NUM_ITERS+1];
  cordic_xy_t         y_pipe    [NUM_ITERS+1];
  cordic_z_t          z_pipe    [NUM_ITERS+1];
  quad_t              quad_pipe [NUM_ITERS+1];
  logic [NUM_ITERS:0] vld_pipe, last_pipe;
  logic [NUM_ITERS:0][3:0] strb_pipe;

  // Fold: quadrant split off, gain pre-compensated so the output needs no divide.
  cordic_xy_t f_x;
  cordic_z_t  f_z;
  quad_t      f_quad;
  logic       f_vld, f_last;
  logic [3:0] f_strb;

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      f_x    <= '0;
      f_z    <= '0;
      f_quad <= '0;
      f_vld  <= 1'b0;
      f_last <= 1'b0;
      f_strb <= 4'hF;
    end else if (en) begin
      f_x    <= cordic_xy_t'({2'b00, 32'(mag) * 32'(INV_K)});
      f_z    <= {3'b000, angle[13:0]};
      f_quad <= angle[15:14];
      f_vld  <= s00_axis.tvalid;
      f_last <= s00_axis.tlast;
      f_strb <= s00_axis.tstrb;
    end
  end

  assign x_pipe[0]    = f_x;
  assign y_pipe[0]    = '0;
  assign z_pipe[0]    = f_z;
  assign quad_pipe[0] = f_quad;
  assign vld_pipe[0]  = f_vld;
  assign last_pipe[0] = f_last;
  assign strb_pipe[0] = f_strb;

  for (genvar i = 0; i < NUM_ITERS; i++) begin : g_stage
    cordic_rot_stage #(.SHIFT(i), .ATAN(ATAN_TAB[i])) u_stage (
      .clk    (s00_axis_aclk),
      .rst_n  (s00_axis_aresetn),
      .en     (en),
      .x      (x_pipe[i]),
      .y      (y_pipe[i]),
      .z      (z_pipe[i]),
      .quad   (quad_pipe[i]),
      .vld    (vld_pipe[i]),
      .last   (last_pipe[i]),
      .strb   (strb_pipe[i]),
      .x_q    (x_pipe[i+1]),
      .y_q    (y_pipe[i+1]),
      .z_q    (z_pipe[i+1]),
      .quad_q (quad_pipe[i+1]),
      .vld_q  (vld_pipe[i+1]),
      .last_q (last_pipe[i+1]),
      .strb_q (strb_pipe[i+1])
    );
  end

  // Unfold: round/saturate, then rotate back by the stripped quadrant.
  logic signed [15:0] xr, yr, i_nx, q_nx;
  assign xr = round_sat(x_pipe[NUM_ITERS]);
  assign yr = round_sat(y_pipe[NUM_ITERS]);

  always_comb begin
    i_nx = xr;
    q_nx = yr;
    case (quad_pipe[NUM_ITERS])
      2'd1:    begin i_nx = -yr; q_nx = xr;  end
      2'd2:    begin i_nx = -xr; q_nx = -yr; end
      2'd3:    begin i_nx = yr;  q_nx = -xr; end
      default: ;
    endcase
  end

  logic                              o_vld, o_last;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] o_data;
  logic [3:0]                        o_strb;

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      o_vld  <= 1'b0;
      o_last <= 1'b0;
      o_data <= '0;
      o_strb <= 4'hF;
    end else if (en) begin
      o_vld  <= vld_pipe[NUM_ITERS];
      o_last <= last_pipe[NUM_ITERS];
      o_data <= {q_nx, i_nx};
      o_strb <= strb_pipe[NUM_ITERS];
    end
  end

  assign m00_axis.tvalid = o_vld;
  assign m00_axis.tlast  = o_last;
  assign m00_axis.tdata  = o_data;
  assign m00_axis.tstrb  = o_strb;
endmodule

// File: tb/tb_cordic_polar_to_rect.sv
// Bench for cordic_polar_to_rect: floating-point polar->rect model with tolerances.
module tb_cordic_polar_to_rect;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_polar_to_rect_if #(.DATA_W(32)) s_if();
  cordic_polar_to_rect_if #(.DATA_W(32)) m_if();

  cordic_polar_to_rect #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .NUM_ITERS(15)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis         (s_if),
    .m00_axis         (m_if)
  );

  int vecs = 0;
  int errs = 0;

  typedef struct {
    int         mag;
    int         ang;
    bit         last;
    logic [3:0] strb;
  } beat_t;
  beat_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // mag*cos / mag*sin of the angle, rounded and clamped to the output range
  function automatic void ref_iq(input int mag, input int ang, output int ei, output int eq);
    real th, fi, fq;
    th = 6.283185307179586 * ang / 65536.0;
    fi = mag * $cos(th);
    fq = mag * $sin(th);
    ei = int'(fi);
    eq = int'(fq);
    if (ei > 32767) ei = 32767;
    if (ei < -32767) ei = -32767;
    if (eq > 32767) eq = 32767;
    if (eq < -32767) eq = -32767;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    m_if.tready = 1'b1;
    tick(); tick();
    vecs++; if (m_if.tvalid !== 1'b0) begin errs++; $display("FAIL reset_tvalid got %b want 0", m_if.tvalid); end
    vecs++; if (m_if.tlast !== 1'b0) begin errs++; $display("FAIL reset_tlast got %b want 0", m_if.tlast); end
    vecs++; if (m_if.tdata !== 32'h0) begin errs++; $display("FAIL reset_tdata got %h want 0", m_if.tdata); end
    vecs++; if (m_if.tstrb !== 4'hF) begin errs++; $display("FAIL reset_tstrb got %h want F", m_if.tstrb); end
    vecs++; if (s_if.tready !== 1'b1) begin errs++; $display("FAIL tready_follow1 got %b want 1", s_if.tready); end
    m_if.tready = 1'b0; #1;
    vecs++; if (s_if.tready !== 1'b0) begin errs++; $display("FAIL tready_follow0 got %b want 0", s_if.tready); end
    m_if.tready = 1'b1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single(input string nm, input int mag, input int ang, input int tol);
    int ei, eq, ai, aq, cnt;
    logic [3:0] st;
    st = 4'($urandom_range(15));
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {16'(ang), 16'(mag)};
    s_if.tlast  = 1'b1;
    s_if.tstrb  = st;
    tick();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    cnt = 1;
    while (!m_if.tvalid && cnt < 40) begin tick(); cnt++; end
    vecs++; if (cnt != 17) begin errs++; $display("FAIL %s_latency got %0d want 17", nm, cnt); end
    ref_iq(mag, ang, ei, eq);
    ai = int'($signed(m_if.tdata[15:0]));
    aq = int'($signed(m_if.tdata[31:16]));
    vecs++; if (iabs(ai - ei) > tol) begin errs++; $display("FAIL %s_I got %0d want %0d+-%0d", nm, ai, ei, tol); end
    vecs++; if (iabs(aq - eq) > tol) begin errs++; $display("FAIL %s_Q got %0d want %0d+-%0d", nm, aq, eq, tol); end
    vecs++; if (m_if.tlast !== 1'b1 || m_if.tstrb !== st) begin
      errs++; $display("FAIL %s_side got last=%b strb=%h want last=1 strb=%h", nm, m_if.tlast, m_if.tstrb, st);
    end
    tick();
    vecs++; if (m_if.tvalid !== 1'b0) begin errs++; $display("FAIL %s_single got tvalid=%b want 0", nm, m_if.tvalid); end
  endtask

  // rnd=0: back-to-back burst with a 5-cycle stall at beat 20; rnd=1: random bubbles/backpressure
  task automatic test_stream(input string nm, input int n, input bit rnd);
    int mags[], angs[];
    int sent, got, stall, cyc, ei, eq, ai, aq, tol;
    bit held, stall_done, acc;
    logic [31:0] hold_d;
    beat_t b;
    mags = new[n];
    angs = new[n];
    for (int k = 0; k < n; k++) begin
      mags[k] = rnd ? int'($urandom_range(65535)) : int'($urandom_range(30000));
      angs[k] = int'($urandom_range(65535));
      if (rnd && k % 17 == 3) mags[k] = 0;
    end
    exp_q.delete();
    sent = 0; got = 0; stall = 0; cyc = 0; held = 0; stall_done = 0; hold_d = '0;
    while (got < n && cyc < 3000) begin
      if (!rnd && sent == 19 && !stall_done) begin stall = 5; stall_done = 1; end
      if (stall > 0) begin m_if.tready = 1'b0; stall--; end
      else m_if.tready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (sent < n) begin
        s_if.tvalid = rnd ? ($urandom_range(4) != 0) : 1'b1;
        s_if.tdata  = {16'(angs[sent]), 16'(mags[sent])};
        s_if.tlast  = (sent == n - 1);
        s_if.tstrb  = 4'($urandom_range(15));
      end else begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
      end
      acc = s_if.tvalid && m_if.tready;
      if (acc) begin
        b.mag = mags[sent]; b.ang = angs[sent]; b.last = s_if.tlast; b.strb = s_if.tstrb;
        exp_q.push_back(b);
        sent++;
      end
      if (m_if.tvalid) begin
        if (m_if.tready) begin
          vecs++;
          if (exp_q.size() == 0) begin
            errs++; $display("FAIL %s_extra got unexpected beat %h want none", nm, m_if.tdata);
          end else begin
            b = exp_q.pop_front();
            ref_iq(b.mag, b.ang, ei, eq);
            tol = 3 + b.mag / 2048;
            ai = int'($signed(m_if.tdata[15:0]));
            aq = int'($signed(m_if.tdata[31:16]));
            if (iabs(ai - ei) > tol || iabs(aq - eq) > tol) begin
              errs++; $display("FAIL %s_iq[%0d] got I=%0d Q=%0d want I=%0d Q=%0d +-%0d", nm, got, ai, aq, ei, eq, tol);
            end
            vecs++;
            if (m_if.tlast !== b.last || m_if.tstrb !== b.strb) begin
              errs++; $display("FAIL %s_side[%0d] got last=%b strb=%h want last=%b strb=%h",
                               nm, got, m_if.tlast, m_if.tstrb, b.last, b.strb);
            end
          end
          got++;
          held = 0;
        end else begin
          if (held) begin
            vecs++;
            if (m_if.tdata !== hold_d) begin errs++; $display("FAIL %s_hold got %h want %h", nm, m_if.tdata, hold_d); end
          end
          hold_d = m_if.tdata;
          held = 1;
        end
      end
      tick();
      cyc++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    vecs++; if (got != n) begin errs++; $display("FAIL %s_count got %0d want %0d", nm, got, n); end
    for (int k = 0; k < 20; k++) begin
      tick();
      vecs++; if (m_if.tvalid !== 1'b0) begin errs++; $display("FAIL %s_drain got tvalid=%b want 0", nm, m_if.tvalid); end
    end
  endtask

  task automatic test_reset_midstream();
    int stale;
    m_if.tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = {16'($urandom_range(65535)), 16'(1000 + k)};
      s_if.tstrb  = 4'h3;
      s_if.tlast  = (k == 9);
      tick();
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    rst_n = 1'b0;
    tick();
    vecs++; if (m_if.tvalid !== 1'b0) begin errs++; $display("FAIL rst_mid_tvalid got %b want 0", m_if.tvalid); end
    vecs++; if (m_if.tstrb !== 4'hF) begin errs++; $display("FAIL rst_mid_tstrb got %h want F", m_if.tstrb); end
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (m_if.tvalid !== 1'b0) stale++;
    end
    vecs++; if (stale != 0) begin errs++; $display("FAIL rst_mid_stale got %0d beats want 0", stale); end
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    s_if.tstrb  = 4'hF;
    m_if.tready = 1'b1;
    test_reset();
    test_single("ang0",    10000, 0,     2);
    test_single("ang90",   10000, 16384, 2);
    test_single("ang225",  20000, 40960, 3);
    test_single("ang180",  10000, 32768, 2);
    test_single("ang270",  10000, 49152, 2);
    test_single("wrap",    10000, 65535, 2);
    test_single("sat",     40000, 0,     2);
    test_single("zero_a",  0,     12345, 0);
    test_single("zero_b",  0,     50000, 0);
    test_stream("burst", 64, 1'b0);
    test_stream("rand", 200, 1'b1);
    test_reset_midstream();
    test_single("post_rst", 30000, 8192, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
